// File: rtl/n_term_ram_io_param.sv
`default_nettype none
// ============================================================================
// Module  : n_term_ram_io_param
// Brief   : North terminal tile for the RAM IO column. Loops N wire groups
//           back south (direct, registered or LFSR test pattern) and forwards
//           FrameStrobe / UserCLK to the neighbouring tile.
// Revision: 1.0  initial release
// ============================================================================
module n_term_ram_io_param #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int N1_WIDTH        = 4,
    parameter int N2_WIDTH        = 8,
    parameter int N4_WIDTH        = 16,
    parameter int CFG_FRAME       = 0,
    parameter int NoConfigBits    = 5
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic [N1_WIDTH-1:0]        N1END,
    input  logic [N2_WIDTH-1:0]        N2MID,
    input  logic [N2_WIDTH-1:0]        N2END,
    input  logic [N4_WIDTH-1:0]        N4END,
    output logic [N1_WIDTH-1:0]        S1BEG,
    output logic [N2_WIDTH-1:0]        S2BEG,
    output logic [N2_WIDTH-1:0]        S2BEGb,
    output logic [N4_WIDTH-1:0]        S4BEG,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo,
    output logic [NoConfigBits-1:0]    ConfigBits_O
);

    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;

    logic [NoConfigBits-1:0] cfg_q,  cfg_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [N1_WIDTH-1:0]     n1_q,   n1_d;
    logic [N2_WIDTH-1:0]     n2m_q,  n2m_d;
    logic [N2_WIDTH-1:0]     n2e_q,  n2e_d;
    logic [N4_WIDTH-1:0]     n4_q,   n4_d;
    logic                    pat_en;
    logic                    lfsr_fb;
    logic                    unused_frame_bits;

    assign pat_en            = cfg_q[4];
    assign unused_frame_bits = ^FrameData[FrameBitsPerRow-1:NoConfigBits];

    always_comb begin
        cfg_d = cfg_q;
        if (FrameStrobe[CFG_FRAME]) begin
            cfg_d = FrameData[NoConfigBits-1:0];
        end
        // pipeline flops capture unconditionally so a mode switch shows last cycle's input
        n1_d    = N1END;
        n2m_d   = N2MID;
        n2e_d   = N2END;
        n4_d    = N4END;
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = pat_en ? {lfsr_q[14:0], lfsr_fb} : C_LFSR_SEED;
    end

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            cfg_q  <= '0;
            lfsr_q <= C_LFSR_SEED;
            n1_q   <= '0;
            n2m_q  <= '0;
            n2e_q  <= '0;
            n4_q   <= '0;
        end else begin
            cfg_q  <= cfg_d;
            lfsr_q <= lfsr_d;
            n1_q   <= n1_d;
            n2m_q  <= n2m_d;
            n2e_q  <= n2e_d;
            n4_q   <= n4_d;
        end
    end

    // Output select per bit: pattern beats registered beats pass-through
    generate
        for (genvar i = 0; i < N1_WIDTH; i++) begin : g_s1
            assign S1BEG[i] = pat_en ? lfsr_q[i % 16] : (cfg_q[0] ? n1_q[i] : N1END[i]);
        end
        for (genvar i = 0; i < N2_WIDTH; i++) begin : g_s2
            assign S2BEG[i]  = pat_en ? lfsr_q[i % 16] : (cfg_q[1] ? n2m_q[i] : N2MID[i]);
            assign S2BEGb[i] = pat_en ? lfsr_q[i % 16] : (cfg_q[2] ? n2e_q[i] : N2END[i]);
        end
        for (genvar i = 0; i < N4_WIDTH; i++) begin : g_s4
            assign S4BEG[i] = pat_en ? lfsr_q[i % 16] : (cfg_q[3] ? n4_q[i] : N4END[i]);
        end
        for (genvar i = 0; i < MaxFramesPerCol; i++) begin : g_fs_buf
            assign FrameStrobe_O[i] = FrameStrobe[i];
        end
    endgenerate

    assign UserCLKo     = UserCLK;
    assign ConfigBits_O = cfg_q;

endmodule
`default_nettype wire
